// File: rtl/cle_seq_pkg.sv
// cle_seq_pkg: state codes, bus command codes and counter sizing
// shared by the CLE serial sequencer files.
package cle_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEAD = 3'd1,
    S_H0   = 3'd2,
    S_H1   = 3'd3,
    S_STOP = 3'd4,
    S_HUNT = 3'd5,
    S_RXH0 = 3'd6,
    S_RXH1 = 3'd7
  } state_t;

  localparam logic [3:0] CMD_LOAD  = 4'h2;
  localparam logic [3:0] CMD_TX    = 4'hA;
  localparam logic [3:0] CMD_RX    = 4'h9;
  localparam logic [3:0] CMD_ABORT = 4'hE;

  // bits needed to count 0..n-1
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cle_seq_timer.sv
// cle_seq_timer: half-bit counter for the CLE sequencer, flags the
// last count of a half-bit and the mid-half sample point.
module cle_seq_timer #(
  parameter int HALF_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic half_wrap,
  output logic mid
);
  import cle_seq_pkg::*;

  localparam int CW = cnt_w(HALF_CYC);

  logic [CW-1:0] count;

  assign half_wrap = (count == CW'(HALF_CYC - 1));
  assign mid       = (count == CW'(HALF_CYC / 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr || half_wrap)
      count <= '0;
    else
      count <= count + CW'(1);
  end

endmodule

// File: rtl/cle_serial_seq.sv
// cle_serial_seq: bus-commanded Manchester serial TX/RX sequencer.
// Define CLE_SEQ_PARITY_EN to append/check an odd parity bit.
module cle_serial_seq #(
  parameter int DATA_W   = 8,
  parameter int HALF_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              br_w,
  input  logic [3:0]        ba,
  input  logic [DATA_W-1:0] wdata,
  input  logic              sd_in,
  output logic              sd_out,
  output logic              sd_oe,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        state
);
  import cle_seq_pkg::*;

`ifdef CLE_SEQ_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int BW = cnt_w(NBITS);

  state_t st, st_n;
  logic half_wrap, mid, clr;
  logic idle, fin, last_bit, tx_bit;
  logic armed, sd_prev, rise, s0;
  logic cmd_load, cmd_tx, cmd_rx, cmd_abort;
  logic [BW-1:0] bitcnt;
  logic [DATA_W-1:0] tx_reg, tx_sh, rx_sh, rx_nxt;
`ifdef CLE_SEQ_PARITY_EN
  logic par_bit, tx_par;
`endif

  assign idle = (st == S_IDLE);

  // only ABORT is honoured while a transfer is running
  always_comb begin
    cmd_load  = 1'b0;
    cmd_tx    = 1'b0;
    cmd_rx    = 1'b0;
    cmd_abort = 1'b0;
    if (sel && br_w) begin
      unique case (1'b1)
        ba == CMD_LOAD:  cmd_load  = idle;
        ba == CMD_TX:    cmd_tx    = idle;
        ba == CMD_RX:    cmd_rx    = idle;
        ba == CMD_ABORT: cmd_abort = !idle;
        default: ;
      endcase
    end
  end

  assign rise     = sd_in & ~sd_prev;
  assign clr      = idle | ((st == S_HUNT) & ~armed & ~rise);
  assign last_bit = (bitcnt == BW'(NBITS - 1));
  assign rx_nxt   = {rx_sh[DATA_W-2:0], sd_in};
  assign fin      = half_wrap &
                    ((st == S_STOP) | ((st == S_RXH1) & last_bit));

`ifdef CLE_SEQ_PARITY_EN
  assign par_bit = (bitcnt == BW'(DATA_W));
  assign tx_bit  = par_bit ? tx_par : tx_sh[DATA_W-1];
`else
  assign tx_bit  = tx_sh[DATA_W-1];
`endif

  cle_seq_timer #(
    .HALF_CYC (HALF_CYC)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .half_wrap (half_wrap),
    .mid       (mid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      st <= S_IDLE;
    else
      st <= st_n;
  end

  always_comb begin
    st_n = st;
    unique case (st)
      S_IDLE: begin
        if (cmd_tx)
          st_n = S_LEAD;
        else if (cmd_rx)
          st_n = S_HUNT;
      end
      S_LEAD: if (half_wrap) st_n = S_H0;
      S_H0:   if (half_wrap) st_n = S_H1;
      S_H1:   if (half_wrap) st_n = last_bit ? S_STOP : S_H0;
      S_STOP: if (half_wrap) st_n = S_IDLE;
      S_HUNT: if (armed && half_wrap) st_n = S_RXH0;
      S_RXH0: if (half_wrap) st_n = S_RXH1;
      S_RXH1: if (half_wrap) st_n = last_bit ? S_IDLE : S_RXH0;
    endcase
    if (cmd_abort)
      st_n = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_reg  <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rdata   <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
      bitcnt  <= '0;
      armed   <= 1'b0;
      sd_prev <= 1'b0;
      s0      <= 1'b0;
`ifdef CLE_SEQ_PARITY_EN
      tx_par  <= 1'b0;
`endif
    end else begin
      sd_prev <= sd_in;
      done    <= fin & ~cmd_abort;
      armed   <= (st == S_HUNT) & ~cmd_abort & (armed | rise);
      if (cmd_load)
        tx_reg <= wdata;
      if (cmd_tx) begin
        tx_sh <= tx_reg;
`ifdef CLE_SEQ_PARITY_EN
        tx_par <= ~^tx_reg;
`endif
      end
      if (cmd_rx)
        err <= 1'b0;
      if (idle)
        bitcnt <= '0;
      else if (half_wrap && (st == S_H1 || st == S_RXH1))
        bitcnt <= bitcnt + BW'(1);
      if (half_wrap && st == S_H1)
        tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
      if (mid && st == S_RXH0)
        s0 <= sd_in;
      // both halves equal is a Manchester violation
      if (mid && st == S_RXH1) begin
        if (sd_in == s0)
          err <= 1'b1;
`ifdef CLE_SEQ_PARITY_EN
        if (par_bit) begin
          if (!(^rx_sh ^ sd_in))
            err <= 1'b1;
        end else begin
          rx_sh <= rx_nxt;
        end
`else
        rx_sh <= rx_nxt;
`endif
      end
      // with HALF_CYC=2 the last sample lands on the wrap edge
      if (fin && st == S_RXH1 && !cmd_abort) begin
`ifdef CLE_SEQ_PARITY_EN
        rdata <= (mid && !par_bit) ? rx_nxt : rx_sh;
`else
        rdata <= mid ? rx_nxt : rx_sh;
`endif
      end
    end
  end

  always_comb begin
    sd_out = 1'b0;
    sd_oe  = 1'b0;
    unique case (st)
      S_LEAD: begin
        sd_out = 1'b1;
        sd_oe  = 1'b1;
      end
      S_H0: begin
        sd_out = ~tx_bit;
        sd_oe  = 1'b1;
      end
      S_H1: begin
        sd_out = tx_bit;
        sd_oe  = 1'b1;
      end
      S_STOP: sd_oe = 1'b1;
      default: ;
    endcase
  end

  assign busy  = ~idle;
  assign state = st;

endmodule

// File: tb/tb_cle_serial_seq.sv
// tb_cle_serial_seq: scoreboard bench, instance A transmits and
// instance B receives over a loopback line with optional corruption.
module tb_cle_serial_seq;
  import cle_seq_pkg::*;

  localparam int DW = 8;
  localparam int HC = 4;
`ifdef CLE_SEQ_PARITY_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif
  localparam int TXLEN = HC * (2 * NB + 2);

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic a_sel, a_brw, b_sel, b_brw;
  logic [3:0] a_ba, b_ba;
  logic [DW-1:0] a_wd, b_wd, a_rd, b_rd;
  logic a_sdo, a_oe, a_busy, a_done, a_err;
  logic b_sdo, b_oe, b_busy, b_done, b_err;
  logic [2:0] a_st, b_st;
  logic a_sdi, b_sdi;

  int cyc = 0;
  int inv_lo = -1;
  int inv_hi = -1;
  int errors = 0;
  int checks = 0;
  int a_bcnt = 0;
  logic a_pd = 1'b0;
  logic b_pd = 1'b0;

  exp_t qa[$];
  exp_t qb[$];
  logic wave_q[$];

  logic [DW-1:0] tx_m, a_rd_m, b_rd_m;
  logic b_err_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign a_sdi = 1'b0;
  assign b_sdi = a_sdo ^ ((cyc >= inv_lo) && (cyc <= inv_hi));

  cle_serial_seq #(.DATA_W(DW), .HALF_CYC(HC)) u_a (
    .clk(clk), .rst_n(rst_n), .sel(a_sel), .br_w(a_brw),
    .ba(a_ba), .wdata(a_wd), .sd_in(a_sdi), .sd_out(a_sdo),
    .sd_oe(a_oe), .rdata(a_rd), .busy(a_busy), .done(a_done),
    .err(a_err), .state(a_st)
  );

  cle_serial_seq #(.DATA_W(DW), .HALF_CYC(HC)) u_b (
    .clk(clk), .rst_n(rst_n), .sel(b_sel), .br_w(b_brw),
    .ba(b_ba), .wdata(b_wd), .sd_in(b_sdi), .sd_out(b_sdo),
    .sd_oe(b_oe), .rdata(b_rd), .busy(b_busy), .done(b_done),
    .err(b_err), .state(b_st)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever a DUT drives the line or
  // signals completion
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      a_bcnt = 0;
      a_pd = 1'b0;
      b_pd = 1'b0;
    end else begin
      if (a_oe) begin
        chk("a_oe_window", wave_q.size() > 0, 1);
        if (wave_q.size() > 0)
          chk("a_sd_out", a_sdo, wave_q.pop_front());
      end
      if (a_pd)
        chk("a_done_width", a_done, 0);
      if (a_done) begin
        chk("a_done_expected", qa.size() > 0, 1);
        if (qa.size() > 0) begin
          e = qa.pop_front();
          chk("a_done_cyc", cyc, e.cyc);
          chk("a_busy_len", a_bcnt, TXLEN);
          chk("a_rdata", a_rd, e.rdata);
          chk("a_err", a_err, e.err);
          chk("a_wave_left", wave_q.size(), 0);
        end
      end
      a_pd = a_done;
      a_bcnt = a_busy ? a_bcnt + 1 : 0;
      if (b_pd)
        chk("b_done_width", b_done, 0);
      if (b_done) begin
        chk("b_done_expected", qb.size() > 0, 1);
        if (qb.size() > 0) begin
          e = qb.pop_front();
          chk("b_done_cyc", cyc, e.cyc);
          chk("b_rdata", b_rd, e.rdata);
          chk("b_err", b_err, e.err);
        end
      end
      b_pd = b_done;
    end
  end

  task automatic cmd_a(input logic [3:0] c, input logic [DW-1:0] d,
                       input logic wr);
    a_sel = 1'b1; a_brw = wr; a_ba = c; a_wd = d;
    @(posedge clk); #1;
    a_sel = 1'b0; a_brw = 1'b0; a_ba = '0; a_wd = '0;
  endtask

  task automatic cmd_b(input logic [3:0] c);
    b_sel = 1'b1; b_brw = 1'b1; b_ba = c;
    @(posedge clk); #1;
    b_sel = 1'b0; b_brw = 1'b0; b_ba = '0;
  endtask

  // expected line: lead ones, per bit ~b then b, stop zeros
  task automatic push_tx(input logic [DW-1:0] w, input int k0);
    exp_t e;
    logic b;
    for (int i = 0; i < HC; i++) wave_q.push_back(1'b1);
    for (int n = 0; n < NB; n++) begin
      b = (n < DW) ? w[DW-1-n] : ~^w;
      for (int i = 0; i < HC; i++) wave_q.push_back(~b);
      for (int i = 0; i < HC; i++) wave_q.push_back(b);
    end
    for (int i = 0; i < HC; i++) wave_q.push_back(1'b0);
    e.rdata = a_rd_m;
    e.err = 1'b0;
    e.cyc = k0 + TXLEN;
    qa.push_back(e);
  endtask

  task automatic do_tx(input logic [DW-1:0] w, input logic ld,
                       output int k0);
    if (ld) begin
      cmd_a(CMD_LOAD, w, 1'b1);
      tx_m = w;
    end
    cmd_a(CMD_TX, '0, 1'b1);
    k0 = cyc;
    push_tx(tx_m, k0);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((a_busy || b_busy || qa.size() > 0 || qb.size() > 0)
           && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_timeout"}, n < 2000, 1);
    if (n >= 2000) begin
      qa.delete(); qb.delete(); wave_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // flip >= 0 corrupts bit 'flip' on B's line: H1 only, or both halves
  task automatic loop(input logic [DW-1:0] w, input int flip,
                      input logic both);
    exp_t e;
    int k0;
    cmd_b(CMD_RX);
    repeat (3) @(posedge clk);
    #1;
    do_tx(w, 1'b1, k0);
    e.rdata = w;
    e.err = 1'b0;
    if (flip >= 0) begin
      inv_lo = k0 + HC + 2 * flip * HC + (both ? 0 : HC);
      inv_hi = k0 + HC + 2 * flip * HC + 2 * HC - 1;
      e.err = 1'b1;
      if (!both && flip < DW)
        e.rdata[DW-1-flip] = ~w[DW-1-flip];
    end
    e.cyc = k0 + HC * (2 * NB + 1);
    qb.push_back(e);
    b_rd_m = e.rdata;
    b_err_m = e.err;
    wait_idle("loop");
    inv_lo = -1;
    inv_hi = -1;
  endtask

  initial begin
    int k0;
    logic [DW-1:0] w;
    rst_n = 1'b0;
    a_sel = 1'b0; a_brw = 1'b0; a_ba = '0; a_wd = '0;
    b_sel = 1'b0; b_brw = 1'b0; b_ba = '0; b_wd = '0;
    tx_m = '0; a_rd_m = '0; b_rd_m = '0; b_err_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", a_st, 0);
    chk("rst_sd_out", a_sdo, 0);
    chk("rst_sd_oe", a_oe, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_err", a_err, 0);
    chk("rst_rdata", a_rd, a_rd_m);
    chk("rst_b_state", b_st, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    do_tx(8'hA5, 1'b1, k0);
    wait_idle("tx_a5");

    // a read cycle and an unused code must not touch tx_reg
    cmd_a(CMD_LOAD, 8'h5A, 1'b0);
    cmd_a(4'h3, 8'h77, 1'b1);
    do_tx('0, 1'b0, k0);
    wait_idle("tx_ignored");

    repeat (3) begin
      w = DW'($urandom);
      do_tx(w, 1'b1, k0);
      wait_idle("tx_rand");
    end

    loop(8'h3C, -1, 1'b0);
    repeat (3) loop(DW'($urandom), -1, 1'b0);

    loop(DW'($urandom), 3, 1'b0);
    cmd_b(CMD_RX);
    b_err_m = 1'b0;
    @(negedge clk);
    chk("b_err_clear", b_err, b_err_m);
    chk("b_hunt_busy", b_busy, 1);
    @(posedge clk); #1;
    cmd_b(CMD_ABORT);
    @(negedge clk);
    chk("b_abort_state", b_st, 0);
    chk("b_abort_rdata", b_rd, b_rd_m);
    @(posedge clk); #1;

    // commands during TX are dropped, then ABORT
    w = DW'($urandom);
    do_tx(w, 1'b1, k0);
    while (cyc < k0 + 9) begin @(posedge clk); #1; end
    cmd_a(CMD_LOAD, 8'hFF, 1'b1);
    cmd_a(CMD_RX, '0, 1'b1);
    while (cyc < k0 + 29) begin @(posedge clk); #1; end
    cmd_a(CMD_ABORT, '0, 1'b1);
    wave_q.delete();
    qa.delete();
    @(negedge clk);
    chk("abort_state", a_st, 0);
    chk("abort_busy", a_busy, 0);
    chk("abort_oe", a_oe, 0);
    repeat (TXLEN) @(posedge clk);
    #1;
    do_tx('0, 1'b0, k0);
    wait_idle("tx_after_abort");

`ifdef CLE_SEQ_PARITY_EN
    do_tx(8'h01, 1'b1, k0);
    wait_idle("tx_par01");
    loop(DW'($urandom), DW, 1'b1);
`endif

    // asynchronous reset in the middle of a transfer
    w = DW'($urandom);
    do_tx(w, 1'b1, k0);
    while (cyc < k0 + 20) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_oe", a_oe, 0);
    chk("rst_mid_busy", a_busy, 0);
    chk("rst_mid_state", a_st, 0);
    qa.delete(); qb.delete(); wave_q.delete();
    tx_m = '0; b_rd_m = '0; b_err_m = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (TXLEN) @(posedge clk);
    #1;
    chk("rst_mid_idle", a_busy, 0);
    chk("rst_mid_b_rdata", b_rd, b_rd_m);
    do_tx('0, 1'b0, k0);
    wait_idle("tx_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
